// File: rtl/bram_port_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_port_master: valid/ready word requests -> 11-word BRAM port cycles,   |
// | 2-entry in-order read response buffer, hardware zero-fill.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module bram_port_master #(
  parameter int DEPTH  = 11,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err_oob,
  output logic [3:0]        bram_WE,
  output logic              bram_EN,
  output logic [DATA_W-1:0] bram_Di,
  output logic [ADDR_W-1:0] bram_A,
  input  logic [DATA_W-1:0] bram_Do
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        clr_idx_q, clr_idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_oob_q, rd_oob_d;
  logic              err_oob_q, err_oob_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              run, oob, accept, pop, room;
  logic [2:0]        pend;
  logic [DATA_W-1:0] cap;

  // Reset also gates the combinational issue path so every output reads 0 while held.
  assign run       = Resetn && (state_q == S_RUN);
  assign oob       = req_idx > LAST_IDX;
  assign pop       = (cnt_q != 2'd0) && rsp_ready;
  assign pend      = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
  assign room      = pend < 3'd2;
  assign req_ready = run && (req_we || room);
  assign accept    = req_valid && req_ready;

  assign clr_busy  = (state_q != S_RUN);
  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_data  = rd_ptr_q ? buf1_q : buf0_q;
  assign err_oob   = err_oob_q;
  assign bram_A    = a_d;
  assign bram_Di   = di_d;
  assign cap       = rd_oob_q ? '0 : bram_Do;

  always_comb begin
    bram_EN = 1'b0;
    bram_WE = 4'h0;
    a_d     = a_q;
    di_d    = di_q;
    if (state_q == S_CLEAR) begin
      bram_EN = 1'b1;
      bram_WE = 4'hF;
      a_d     = ADDR_W'(clr_idx_q) << 2;
      di_d    = '0;
    end else begin
      // A read issued last cycle keeps EN high for its capture cycle.
      if (rd_vld_q && !rd_oob_q) bram_EN = 1'b1;
      if (accept && !oob) begin
        bram_EN = 1'b1;
        bram_WE = req_we ? 4'hF : 4'h0;
        a_d     = ADDR_W'(req_idx) << 2;
        di_d    = req_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_RUN: begin
        clr_idx_d = 4'd0;
        if (clr_start)
          state_d = (rd_vld_q || (accept && !req_we)) ? S_DRAIN : S_CLEAR;
      end
      S_DRAIN: state_d = S_CLEAR;
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 4'd1;
        if (clr_idx_q == LAST_IDX) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    rd_vld_d  = accept && !req_we;
    rd_oob_d  = oob;
    err_oob_d = accept && oob;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (rd_vld_q) begin
      if (wr_ptr_q) buf1_d = cap;
      else          buf0_d = cap;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
  end

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_RUN;
      clr_idx_q <= 4'd0;
      rd_vld_q  <= 1'b0;
      rd_oob_q  <= 1'b0;
      err_oob_q <= 1'b0;
      a_q       <= '0;
      di_q      <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rd_vld_q  <= rd_vld_d;
      rd_oob_q  <= rd_oob_d;
      err_oob_q <= err_oob_d;
      a_q       <= a_d;
      di_q      <= di_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_master.sv
`default_nettype none
// Directed bench for bram_port_master with a behavioural single-port BRAM.
module tb_bram_port_master;

  logic        CLK = 1'b0;
  logic        Resetn;
  logic        clr_start, clr_busy;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_idx;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        err_oob;
  logic [3:0]  bram_WE;
  logic        bram_EN;
  logic [31:0] bram_Di;
  logic [11:0] bram_A;
  logic [31:0] bram_Do;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [0:15];
  logic [31:0] shadow [0:15];

  always #5 CLK = ~CLK;

  bram_port_master dut (
    .CLK(CLK), .Resetn(Resetn), .clr_start(clr_start), .clr_busy(clr_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_idx(req_idx), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err_oob(err_oob),
    .bram_WE(bram_WE), .bram_EN(bram_EN), .bram_Di(bram_Di),
    .bram_A(bram_A), .bram_Do(bram_Do)
  );

  always @(posedge CLK) begin
    if (bram_EN) begin
      if (bram_WE == 4'hF) mem[bram_A[5:2]] <= bram_Di;
      bram_Do <= mem[bram_A[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] idx, input logic [31:0] wd);
    req_valid = v; req_we = we; req_idx = idx; req_wdata = wd;
  endtask

  // Eleven back-to-back reads with rsp_ready held high, checked against the shadow copy.
  task automatic sweep_reads(input string tag);
    rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      drive(1'b1, 1'b0, 4'(i), 32'h0);
      #1;
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      if (i >= 2) begin
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_data, shadow[i-2]);
      end
    end
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0); #1;
    check({tag, "_data9"}, rsp_data, shadow[9]);
    tick(); #1;
    check({tag, "_data10"}, rsp_data, shadow[10]);
    tick(); #1;
    check({tag, "_empty"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    bram_Do = 32'h0;
    Resetn = 1'b0; clr_start = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'h0);
    repeat (3) tick();
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_en", 32'(bram_EN), 32'd0);
    check("rst_a", 32'(bram_A), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    Resetn = 1'b1;

    // 1: write then read idx3
    tick(); drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF); #1;
    check("t1_wr_ready", 32'(req_ready), 32'd1);
    check("t1_wr_we", 32'(bram_WE), 32'hF);
    check("t1_wr_a", 32'(bram_A), 32'd12);
    check("t1_wr_di", bram_Di, 32'hDEADBEEF);
    shadow[3] = 32'hDEADBEEF;
    tick(); drive(1'b1, 1'b0, 4'd3, 32'h0); #1;
    check("t1_rd_en", 32'(bram_EN), 32'd1);
    check("t1_rd_we", 32'(bram_WE), 32'd0);
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0); #1;
    check("t1_cap_en", 32'(bram_EN), 32'd1);
    check("t1_n1_vld", 32'(rsp_valid), 32'd0);
    tick(); #1;
    check("t1_n2_vld", 32'(rsp_valid), 32'd1);
    check("t1_n2_data", rsp_data, 32'hDEADBEEF);
    check("t1_idle_en", 32'(bram_EN), 32'd0);
    check("t1_idle_a", 32'(bram_A), 32'd12);
    rsp_ready = 1'b1;

    // 2: back-to-back reads
    sweep_reads("t2");

    // 3: backpressure with rsp_ready low
    rsp_ready = 1'b0;
    tick(); drive(1'b1, 1'b0, 4'd1, 32'h0); #1;
    check("t3_r1_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b1, 1'b0, 4'd2, 32'h0); #1;
    check("t3_r2_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b1, 1'b0, 4'd4, 32'h0); #1;
    check("t3_r3_stall", 32'(req_ready), 32'd0);
    tick(); #1;
    check("t3_full_stall", 32'(req_ready), 32'd0);
    check("t3_head1", rsp_data, shadow[1]);
    rsp_ready = 1'b1; #1;
    check("t3_ready_back", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0); #1;
    check("t3_head2", rsp_data, shadow[2]);
    tick(); #1;
    check("t3_head4", rsp_data, shadow[4]);
    tick(); #1;
    check("t3_empty", 32'(rsp_valid), 32'd0);

    // 4: clear with a read in flight
    tick(); drive(1'b1, 1'b0, 4'd3, 32'h0);
    tick(); drive(1'b0, 1'b1, 4'd0, 32'h0); clr_start = 1'b1; #1;
    check("t4_busy_pre", 32'(clr_busy), 32'd0);
    tick(); clr_start = 1'b0; #1;
    check("t4_drain_busy", 32'(clr_busy), 32'd1);
    check("t4_drain_ready", 32'(req_ready), 32'd0);
    check("t4_old_data", rsp_data, 32'hDEADBEEF);
    for (int k = 0; k < 11; k++) begin
      tick(); #1;
      check("t4_clr_busy", 32'(clr_busy), 32'd1);
      check("t4_clr_en", 32'(bram_EN), 32'd1);
      check("t4_clr_we", 32'(bram_WE), 32'hF);
      check("t4_clr_a", 32'(bram_A), 32'(k * 4));
      check("t4_clr_di", bram_Di, 32'd0);
      shadow[k] = 32'd0;
    end
    tick(); req_we = 1'b0; #1;
    check("t4_done_busy", 32'(clr_busy), 32'd0);
    check("t4_done_ready", 32'(req_ready), 32'd1);
    sweep_reads("t4rb");

    // 5: out-of-range read and write
    tick(); drive(1'b1, 1'b0, 4'd12, 32'h0); #1;
    check("t5_rd_ready", 32'(req_ready), 32'd1);
    check("t5_rd_en", 32'(bram_EN), 32'd0);
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0); #1;
    check("t5_rd_oob", 32'(err_oob), 32'd1);
    check("t5_rd_en1", 32'(bram_EN), 32'd0);
    tick(); #1;
    check("t5_oob_clr", 32'(err_oob), 32'd0);
    check("t5_rsp_vld", 32'(rsp_valid), 32'd1);
    check("t5_rsp_data", rsp_data, 32'd0);
    tick(); drive(1'b1, 1'b1, 4'd15, 32'h12345678); #1;
    check("t5_wr_en", 32'(bram_EN), 32'd0);
    check("t5_wr_we", 32'(bram_WE), 32'd0);
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0); #1;
    check("t5_wr_oob", 32'(err_oob), 32'd1);
    check("t5_mem15", mem[15], 32'h1000_000F);

    // 6: reset in the middle of a clear
    rsp_ready = 1'b0;
    tick(); drive(1'b1, 1'b0, 4'd1, 32'h0);
    tick(); drive(1'b0, 1'b0, 4'd0, 32'h0);
    tick(); clr_start = 1'b1; #1;
    check("t6_buffered", 32'(rsp_valid), 32'd1);
    tick(); clr_start = 1'b0;
    repeat (5) tick();
    #1;
    check("t6_at_idx5", 32'(bram_A), 32'd20);
    Resetn = 1'b0; #1;
    check("t6_rst_busy", 32'(clr_busy), 32'd0);
    check("t6_rst_en", 32'(bram_EN), 32'd0);
    check("t6_rst_we", 32'(bram_WE), 32'd0);
    check("t6_rst_a", 32'(bram_A), 32'd0);
    check("t6_rst_vld", 32'(rsp_valid), 32'd0);
    tick(); Resetn = 1'b1; #1;
    check("t6_rel_ready", 32'(req_ready), 32'd1);
    check("t6_rel_vld", 32'(rsp_valid), 32'd0);
    tick(); #1;
    check("t6_rel_busy", 32'(clr_busy), 32'd0);
    check("t6_rel_vld2", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
